// File: rtl/rr_onehot_arbiter_if.sv
// rr_onehot_arbiter_if: request/release inputs and registered grant outputs of the round-robin arbiter
interface rr_onehot_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]         req_i;
  logic                       done_i;
  logic [NUM_REQ-1:0]         gnt_o;
  logic                       gnt_valid_o;
  logic [$clog2(NUM_REQ)-1:0] gnt_idx_o;
  logic                       timeout_o;
  modport master (output req_i, done_i, input gnt_o, gnt_valid_o, gnt_idx_o, timeout_o);
  modport slave  (input req_i, done_i, output gnt_o, gnt_valid_o, gnt_idx_o, timeout_o);
endinterface

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: hold-until-release round-robin arbiter driving a one-hot mux select; ARB_HOLD_LIMIT_EN adds a forced release after MAX_HOLD cycles
module rr_onehot_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input logic                 clk_i,
  input logic                 reset_i,
  rr_onehot_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               valid_q;
  logic [IW-1:0]      idx_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      win_d;
  logic               normal_rel;
  logic               forced_rel;
  assign normal_rel      = bus.done_i | ~bus.req_i[idx_q];
  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_valid_o = valid_q;
  assign bus.gnt_idx_o   = idx_q;
  // Cyclic search from ptr: walk offsets high to low so the smallest offset overwrites last and wins
  always_comb begin
    int j;
    win_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (bus.req_i[j]) win_d = IW'(j);
    end
  end
  // Grant FSM: a release always passes through IDLE so the mux sees a zero select between owners
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else if (state_q == IDLE) begin
      if (|bus.req_i) begin
        state_q <= GRANT;
        gnt_q   <= NUM_REQ'(1) << win_d;
        valid_q <= 1'b1;
        idx_q   <= win_d;
      end
    end else if (normal_rel | forced_rel) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    end
  end
`ifdef ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_HOLD);
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
  assign forced_rel    = cnt_q == CW'(MAX_HOLD - 1);
  assign bus.timeout_o = timeout_q;
  // Hold counter sits at zero while idle so each grant starts fresh; timeout flags only releases the limit alone caused
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == GRANT) ? cnt_q + 1'b1 : '0;
      timeout_q <= (state_q == GRANT) && forced_rel && !normal_rel;
    end
  end
`else
  logic unused_hold;
  assign unused_hold   = MAX_HOLD > 1;
  assign forced_rel    = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif
endmodule
